// File: rtl/seg_display_arbiter_pkg.sv
// Shared types and constants for the seven-segment display arbiter.
package seg_disp_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      HOLD   = 2'd1,
      OWN    = 2'd2,
      FREEZE = 2'd3
   } seg_arb_state_t;

   localparam int         MAX_DISPLAY = 9999;
   localparam logic [3:0] DP_OVERFLOW = 4'b1111;

endpackage

// File: rtl/seg_display_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request after i_ptr, wrapping,
// with i_ptr itself scanned last.
module rr_pick #(
   parameter int N  = 4,
   parameter int IW = $clog2(N)
) (
   input  logic [N-1:0]  i_req,
   input  logic [IW-1:0] i_ptr,
   output logic          o_valid,
   output logic [IW-1:0] o_idx
);

   logic [IW-1:0] w_j;

   // Scan from farthest to nearest so the nearest requester after i_ptr wins.
   always_comb begin
      o_valid = 1'b0;
      o_idx   = {IW{1'b0}};
      w_j     = {IW{1'b0}};
      for (int k = N; k >= 1; k--) begin
         w_j = IW'((int'(i_ptr) + k) % N);
         if (i_req[w_j]) begin
            o_valid = 1'b1;
            o_idx   = w_j;
         end else begin
            o_valid = o_valid;
         end
      end
   end

endmodule

// File: rtl/seg_display_arbiter.sv
// Round-robin owner of a shared 4-digit display with a minimum on-screen time
// per owner; values above 9999 are shown as 9999 with all decimal points lit.
module seg_display_arbiter
   import seg_disp_pkg::*;
#(
   parameter int NUM_REQ     = 4,
   parameter int INPUT_WIDTH = 14,
   parameter int HOLD_CYCLES = 1024
) (
   input  logic                           i_clk,
   input  logic                           i_rst_n,
   input  logic [NUM_REQ-1:0]             req,
   input  logic [NUM_REQ*INPUT_WIDTH-1:0] req_number,
   input  logic [NUM_REQ*4-1:0]           req_dp,
   output logic [NUM_REQ-1:0]             grant,
   output logic [$clog2(NUM_REQ)-1:0]     owner,
   output logic [INPUT_WIDTH-1:0]         number,
   output logic [3:0]                     decimal_points,
   output logic                           busy
);

   localparam int                     OW        = $clog2(NUM_REQ);
   localparam int                     CW        = $clog2(HOLD_CYCLES);
   localparam logic [CW-1:0]          CNT_LOAD  = CW'(HOLD_CYCLES - 1);
   localparam logic [INPUT_WIDTH-1:0] SAT_LIMIT = INPUT_WIDTH'(MAX_DISPLAY);

   seg_arb_state_t         r_state, w_state_nxt;
   logic [CW-1:0]          r_cnt, w_cnt_nxt;
   logic [NUM_REQ-1:0]     r_grant, w_grant_nxt;
   logic [OW-1:0]          r_owner, w_owner_nxt;
   logic [INPUT_WIDTH-1:0] r_number, w_number_nxt;
   logic [3:0]             r_dp, w_dp_nxt;
   logic                   r_busy, w_busy_nxt;

   logic                   w_pick_valid;
   logic [OW-1:0]          w_pick_idx;
   logic                   w_arb, w_track, w_release;
   logic                   w_cnt_zero, w_owner_req;
   logic [OW-1:0]          w_src;
   logic [INPUT_WIDTH-1:0] w_src_num;
   logic [3:0]             w_src_dp;

   rr_pick #(.N(NUM_REQ)) u_pick (
      .i_req   (req),
      .i_ptr   (r_owner),
      .o_valid (w_pick_valid),
      .o_idx   (w_pick_idx)
   );

   assign w_cnt_zero  = (r_cnt == {CW{1'b0}});
   assign w_owner_req = req[r_owner];

   // State register and hold counter.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state <= IDLE;
         r_cnt   <= {CW{1'b0}};
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   // Next state; an expired HOLD settles exactly as OWN would, so the slot is HOLD_CYCLES long.
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_arb       = 1'b0;
      w_track     = 1'b0;
      w_release   = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_pick_valid) begin
               w_arb = 1'b1;
            end else begin
               w_state_nxt = IDLE;
            end
         end
         HOLD, OWN: begin
            if ((r_state == OWN) || w_cnt_zero) begin
               if (w_pick_valid && (w_pick_idx != r_owner)) begin
                  w_arb = 1'b1;
               end else if (w_pick_valid) begin
                  w_state_nxt = OWN;
                  w_track     = 1'b1;
               end else begin
                  w_state_nxt = IDLE;
                  w_release   = 1'b1;
               end
            end else if (w_owner_req) begin
               w_track   = 1'b1;
               w_cnt_nxt = r_cnt - CW'(1);
            end else begin
               w_state_nxt = FREEZE;
               w_release   = 1'b1;
               w_cnt_nxt   = r_cnt - CW'(1);
            end
         end
         FREEZE: begin
            if (w_cnt_zero && w_pick_valid) begin
               w_arb = 1'b1;
            end else if (w_cnt_zero) begin
               w_state_nxt = IDLE;
            end else begin
               w_cnt_nxt = r_cnt - CW'(1);
            end
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase
      if (w_arb) begin
         w_state_nxt = HOLD;
         w_cnt_nxt   = CNT_LOAD;
      end else begin
         w_cnt_nxt = w_cnt_nxt;
      end
   end

   // Next output values: grant/owner on arbitration, saturated display load when tracking.
   always_comb begin
      w_src        = w_arb ? w_pick_idx : r_owner;
      w_src_num    = req_number[int'(w_src) * INPUT_WIDTH +: INPUT_WIDTH];
      w_src_dp     = req_dp[int'(w_src) * 4 +: 4];
      w_grant_nxt  = r_grant;
      w_owner_nxt  = r_owner;
      w_number_nxt = r_number;
      w_dp_nxt     = r_dp;
      if (w_arb) begin
         w_grant_nxt = NUM_REQ'(1'b1) << w_pick_idx;
         w_owner_nxt = w_pick_idx;
      end else if (w_release) begin
         w_grant_nxt = {NUM_REQ{1'b0}};
      end else begin
         w_grant_nxt = r_grant;
      end
      if ((w_arb || w_track) && (w_src_num > SAT_LIMIT)) begin
         w_number_nxt = SAT_LIMIT;
         w_dp_nxt     = DP_OVERFLOW;
      end else if (w_arb || w_track) begin
         w_number_nxt = w_src_num;
         w_dp_nxt     = w_src_dp;
      end else begin
         w_number_nxt = r_number;
      end
      w_busy_nxt = (w_state_nxt != IDLE);
   end

   // Output registers.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_grant  <= {NUM_REQ{1'b0}};
         r_owner  <= OW'(NUM_REQ - 1);
         r_number <= {INPUT_WIDTH{1'b0}};
         r_dp     <= 4'b0000;
         r_busy   <= 1'b0;
      end else begin
         r_grant  <= w_grant_nxt;
         r_owner  <= w_owner_nxt;
         r_number <= w_number_nxt;
         r_dp     <= w_dp_nxt;
         r_busy   <= w_busy_nxt;
      end
   end

   assign grant          = r_grant;
   assign owner          = r_owner;
   assign number         = r_number;
   assign decimal_points = r_dp;
   assign busy           = r_busy;

endmodule
